mm2s_cntrl_parser: RTL and testbench

Parametrised receiver for the AXI DMA MM2S control stream. It replaces the always-ready sink on the control channel of the AES core: it validates the flag word, captures the application words into a register bank, and hands the bank to the AES datapath (key/IV/mode) through a valid/ready handshake. It backpressures the DMA while a captured descriptor has not been consumed, and flags or drops malformed packets.

---
 rtl/mm2s_cntrl_parser.sv | 135 +++++++++++++
 tb/tb_mm2s_cntrl_parser.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mm2s_cntrl_parser.sv
// Receiver for the AXI DMA MM2S control stream: checks the flag word, captures the
// application words and offers them to the AES datapath through a valid/ready handshake.
module mm2s_cntrl_parser #(
  parameter int         C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32,
  parameter int         C_APP_WORDS                     = 5,
  parameter logic [3:0] C_FLAG_NIBBLE                   = 4'hA,
  parameter int         C_CNT_WIDTH                     = 8
) (
  input  logic                                                   m_axi_mm2s_aclk,
  input  logic                                                   mm2s_cntrl_reset_out_n,
  input  logic [C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH-1:0]             m_axis_mm2s_cntrl_tdata,
  input  logic [C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH/8-1:0]           m_axis_mm2s_cntrl_tkeep,
  input  logic                                                   m_axis_mm2s_cntrl_tvalid,
  input  logic                                                   m_axis_mm2s_cntrl_tlast,
  output logic                                                   m_axis_mm2s_cntrl_tready,
  output logic [27:0]                                            cntrl_flag,
  output logic [C_APP_WORDS*C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH-1:0] cntrl_app,
  output logic [1:0]                                             cntrl_err,
  output logic                                                   cntrl_valid,
  input  logic                                                   cntrl_ready,
  output logic [C_CNT_WIDTH-1:0]                                 cntrl_drop_cnt
);

  localparam int W     = C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH;
  localparam int IDX_W = (C_APP_WORDS > 1) ? $clog2(C_APP_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C_APP_WORDS - 1);

  typedef enum logic [1:0] {S_FLAG, S_APP, S_DRAIN, S_HOLD} state_t;

  state_t                   state_q, state_d;
  logic                     tready_q, tready_d;
  logic                     valid_q, valid_d;
  logic [IDX_W-1:0]         idx_q;
  logic                     dropped_q;
  logic [27:0]              flag_q;
  logic [C_APP_WORDS*W-1:0] app_q;
  logic [1:0]               err_q;
  logic [C_CNT_WIDTH-1:0]   drop_cnt_q;

  logic beat, flag_good, idx_at_last;

  // tready is registered, so a beat can only occur in a state that advertised it.
  assign beat        = m_axis_mm2s_cntrl_tvalid & tready_q;
  assign flag_good   = (m_axis_mm2s_cntrl_tdata[31:28] == C_FLAG_NIBBLE) && (&m_axis_mm2s_cntrl_tkeep);
  assign idx_at_last = (idx_q == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_cntrl_reset_out_n) begin
    if (!mm2s_cntrl_reset_out_n) state_q <= S_FLAG;
    else                         state_q <= state_d;
  end

  // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FLAG: if (beat) begin
        if (flag_good)                     state_d = m_axis_mm2s_cntrl_tlast ? S_HOLD : S_APP;
        else if (!m_axis_mm2s_cntrl_tlast) state_d = S_DRAIN;
      end
      S_APP: if (beat) begin
        if (m_axis_mm2s_cntrl_tlast) state_d = S_HOLD;
        else if (idx_at_last)        state_d = S_DRAIN;
      end
      S_DRAIN: if (beat && m_axis_mm2s_cntrl_tlast) state_d = dropped_q ? S_FLAG : S_HOLD;
      S_HOLD:  if (cntrl_ready) state_d = S_FLAG;
      default: state_d = S_FLAG;
    endcase
  end

  // Handshake outputs are decoded from the next state and registered below.
  always_comb begin
    tready_d = (state_d != S_HOLD);
    valid_d  = (state_d == S_HOLD);
  end

  always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_cntrl_reset_out_n) begin
    if (!mm2s_cntrl_reset_out_n) begin
      tready_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      tready_q <= tready_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: the app bank is a register file that drives outputs directly, so it is reset
  // rather than left as an unreset memory.
  always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_cntrl_reset_out_n) begin
    if (!mm2s_cntrl_reset_out_n) begin
      idx_q      <= '0;
      dropped_q  <= 1'b0;
      flag_q     <= '0;
      app_q      <= '0;
      err_q      <= '0;
      drop_cnt_q <= '0;
    end else if (beat) begin
      case (state_q)
        S_FLAG: begin
          if (flag_good) begin
            flag_q    <= m_axis_mm2s_cntrl_tdata[27:0];
            app_q     <= '0;
            err_q     <= {1'b0, m_axis_mm2s_cntrl_tlast};
            idx_q     <= '0;
            dropped_q <= 1'b0;
          end else begin
            dropped_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + C_CNT_WIDTH'(1);
          end
        end
        S_APP: begin
          for (int k = 0; k < C_APP_WORDS; k++)
            if (idx_q == IDX_W'(k)) app_q[k*W +: W] <= m_axis_mm2s_cntrl_tdata;
          if (m_axis_mm2s_cntrl_tlast) begin
            if (!idx_at_last) err_q[0] <= 1'b1;
          end else if (idx_at_last) begin
            err_q[1] <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_mm2s_cntrl_tready = tready_q;
  assign cntrl_valid              = valid_q;
  assign cntrl_flag               = flag_q;
  assign cntrl_app                = app_q;
  assign cntrl_err                = err_q;
  assign cntrl_drop_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_mm2s_cntrl_parser.sv
// Bench for mm2s_cntrl_parser: directed and random packets against a packet-level model.
`timescale 1ns/1ps
module tb_mm2s_cntrl_parser;
  localparam int W    = 32;
  localparam int KW   = W / 8;
  localparam int NAPP = 5;
  localparam int BW   = NAPP * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  tdata = '0;
  logic [KW-1:0] tkeep = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          cntrl_ready = 1'b0;

  logic          a_tready, a_valid, b_tready, b_valid;
  logic [27:0]   a_flag, b_flag;
  logic [BW-1:0] a_app, b_app;
  logic [1:0]    a_err, b_err;
  logic [7:0]    a_drop;
  logic [1:0]    b_drop;

  int n_assert = 0;
  int n_fail   = 0;
  int drops    = 0;

  logic [W-1:0]  pkt [0:8];
  logic [KW-1:0] pkt_keep0;
  int            pkt_len;

  always #5 clk = ~clk;

  mm2s_cntrl_parser #(.C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH(W), .C_APP_WORDS(NAPP),
                      .C_FLAG_NIBBLE(4'hA), .C_CNT_WIDTH(8)) dut_a (
    .m_axi_mm2s_aclk(clk), .mm2s_cntrl_reset_out_n(rst_n),
    .m_axis_mm2s_cntrl_tdata(tdata), .m_axis_mm2s_cntrl_tkeep(tkeep),
    .m_axis_mm2s_cntrl_tvalid(tvalid), .m_axis_mm2s_cntrl_tlast(tlast),
    .m_axis_mm2s_cntrl_tready(a_tready), .cntrl_flag(a_flag), .cntrl_app(a_app),
    .cntrl_err(a_err), .cntrl_valid(a_valid), .cntrl_ready(cntrl_ready),
    .cntrl_drop_cnt(a_drop));

  mm2s_cntrl_parser #(.C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH(W), .C_APP_WORDS(NAPP),
                      .C_FLAG_NIBBLE(4'hA), .C_CNT_WIDTH(2)) dut_b (
    .m_axi_mm2s_aclk(clk), .mm2s_cntrl_reset_out_n(rst_n),
    .m_axis_mm2s_cntrl_tdata(tdata), .m_axis_mm2s_cntrl_tkeep(tkeep),
    .m_axis_mm2s_cntrl_tvalid(tvalid), .m_axis_mm2s_cntrl_tlast(tlast),
    .m_axis_mm2s_cntrl_tready(b_tready), .cntrl_flag(b_flag), .cntrl_app(b_app),
    .cntrl_err(b_err), .cntrl_valid(b_valid), .cntrl_ready(cntrl_ready),
    .cntrl_drop_cnt(b_drop));

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // base != 0 gives app words base*1, base*2, ...; base == 0 gives random words.
  task automatic make_pkt(input logic [31:0] flag, input logic [KW-1:0] keep0,
                          input int napp, input logic [W-1:0] base);
    pkt[0]    = flag;
    pkt_keep0 = keep0;
    pkt_len   = napp + 1;
    for (int k = 0; k < napp; k++)
      pkt[k+1] = (base != '0) ? base * W'(k + 1) : W'($urandom);
  endtask

  // Entered and left on a negedge; the final negedge is the cycle after the last beat.
  task automatic send_pkt(input bit gaps, input bit no_last);
    int g;
    int t;
    for (int b = 0; b < pkt_len; b++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        tvalid = 1'b0;
        tdata  = W'($urandom);
        tlast  = 1'($urandom);
        @(negedge clk);
      end
      tvalid = 1'b1;
      tdata  = pkt[b];
      tkeep  = (b == 0) ? pkt_keep0 : KW'($urandom);
      tlast  = (b == pkt_len - 1) && !no_last;
      t = 0;
      while (!a_tready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!a_tready) check("beat_timeout", a_tready, 1'b1);
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic check_drops(input string tag);
    check({tag, "_drop_a"}, a_drop, (drops > 255) ? 255 : drops);
    check({tag, "_drop_b"}, b_drop, (drops > 3) ? 3 : drops);
  endtask

  // Packet-level model: a good flag delivers the first NAPP app words (rest zero);
  // fewer words flag short, more words flag long, a bad flag drops the packet.
  task automatic expect_pkt(input string tag, input int hold);
    bit            good;
    int            napp;
    logic [BW-1:0] exp_app;
    logic [1:0]    exp_err;
    good = (pkt[0][31:28] == 4'hA) && (pkt_keep0 == '1);
    napp = pkt_len - 1;
    if (!good) begin
      drops++;
      check({tag, "_drop_valid"}, {a_valid, b_valid}, 2'b00);
      check({tag, "_drop_tready"}, a_tready, 1'b1);
      check_drops(tag);
      return;
    end
    exp_app = '0;
    for (int k = 0; k < NAPP && k < napp; k++) exp_app[k*W +: W] = pkt[k+1];
    exp_err = (napp < NAPP) ? 2'b01 : (napp > NAPP) ? 2'b10 : 2'b00;
    for (int c = 0; c < ((hold == 0) ? 1 : hold); c++) begin
      if (c > 0) @(negedge clk);
      check({tag, "_valid"}, {a_valid, b_valid}, 2'b11);
      check({tag, "_tready_hold"}, a_tready, 1'b0);
      check({tag, "_flag"}, a_flag, pkt[0][27:0]);
      check({tag, "_app"}, a_app, exp_app);
      check({tag, "_err"}, a_err, exp_err);
    end
    check_drops(tag);
    if (hold > 0) cntrl_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_done"}, a_valid, 1'b0);
    check({tag, "_tready_done"}, a_tready, 1'b1);
  endtask

  task automatic run_pkt(input string tag, input int hold, input bit gaps);
    cntrl_ready = (hold == 0);
    send_pkt(gaps, 1'b0);
    expect_pkt(tag, hold);
    cntrl_ready = 1'b0;
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_tready"}, {a_tready, b_tready}, 2'b00);
    check({tag, "_valid"}, {a_valid, b_valid}, 2'b00);
    check({tag, "_err"}, a_err, 2'b00);
    check({tag, "_flag"}, a_flag, 28'h0);
    check({tag, "_app"}, a_app, '0);
    check({tag, "_drop"}, {a_drop, b_drop}, 10'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    int          hold;

    // Reset state and release.
    #1;
    check_reset_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tready_release", a_tready, 1'b0);
    @(negedge clk);
    check("tready_after_clk", a_tready, 1'b1);

    // Nominal packet with cntrl_ready held high.
    make_pkt(32'hA000_0010, '1, 5, 32'h11);
    run_pkt("nominal", 0, 1'b0);

    // Backpressure for 10 cycles, then a second packet offered right away.
    make_pkt(32'hA123_4567, '1, 5, '0);
    run_pkt("backpressure", 10, 1'b0);
    check("second_flag_ready", a_tready, 1'b1);
    make_pkt(32'hA000_0002, '1, 5, '0);
    run_pkt("second", 0, 1'b0);

    // Short, long and flag-only packets.
    make_pkt(32'hA000_0003, '1, 2, 32'h11);
    run_pkt("short", 2, 1'b0);
    make_pkt(32'hA000_0004, '1, 7, '0);
    run_pkt("long", 1, 1'b0);
    make_pkt(32'hAFFF_FFFF, '1, 0, '0);
    run_pkt("flag_only", 0, 1'b0);

    // Bad flag followed by a good packet.
    make_pkt(32'h5000_0000, '1, 5, '0);
    run_pkt("bad_flag", 0, 1'b0);
    make_pkt(32'hA000_0005, '1, 5, '0);
    run_pkt("after_bad", 0, 1'b0);

    // Five more drops saturate the 2-bit counter.
    make_pkt(32'h1000_0000, '1, 3, '0);   run_pkt("bad1", 0, 1'b0);
    make_pkt(32'hA000_0000, 4'b0111, 2, '0); run_pkt("bad_keep", 0, 1'b0);
    make_pkt(32'hB000_0000, '1, 0, '0);   run_pkt("bad_tlast", 0, 1'b0);
    make_pkt(32'h0000_0000, '1, 6, '0);   run_pkt("bad4", 0, 1'b0);
    make_pkt(32'hF000_0000, '1, 1, '0);   run_pkt("bad5", 0, 1'b0);
    check("sat_drop_b", b_drop, 2'd3);

    // Reset in S_APP after two app words, then a full packet.
    make_pkt(32'hA000_0006, '1, 2, 32'h11);
    send_pkt(1'b0, 1'b1);
    rst_n = 1'b0;
    drops = 0;
    #1;
    check_reset_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    make_pkt(32'hA000_0007, '1, 5, 32'h101);
    run_pkt("post_reset", 0, 1'b0);

    // Random packets with tvalid gaps and random backpressure.
    for (int i = 0; i < 40; i++) begin
      f = 32'($urandom);
      if ($urandom_range(0, 3) != 0) f[31:28] = 4'hA;
      hold = $urandom_range(0, 3);
      make_pkt(f, ($urandom_range(0, 5) == 0) ? KW'($urandom) : '1, $urandom_range(0, 8), '0);
      run_pkt("random", hold, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
